mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter POLICY, default 0, meaning tie-break rule: 0 = CPU fixed priority with DMA starvation override, 1 = round-robin.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost DMA contests before DMA is forced to win (POLICY 0 only); range 1..15.
REQ-003 SHALL use one clock; reset is synchronous and active-high (ports clock, reset).
REQ-004 SHALL have ports, in this order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_addr  in  17  CPU word address [15:31]
- cpu_wdata  in  32  CPU write data [0:31]
- cpu_wr_en  in  4  CPU byte enables; 0 = read
- cpu_gnt  out  1  one-cycle grant; command is on the memory bus this cycle
- cpu_rvalid  out  1  cpu_rdata valid, one cycle
- cpu_rdata  out  32  CPU read data
- dma_req, dma_addr, dma_wdata, dma_wr_en, dma_gnt, dma_rvalid, dma_rdata  same widths/meaning for the DMA requester
- memory_address  out  17  word address to memory
- memory_data_out  out  32  write data to memory
- wr_enables  out  4  byte write enables to memory
- memory_data_in  in  32  asynchronous-read data from memory

Function
REQ-005 SHALL arbitrate in cycle N among requesters whose req is high and whose gnt is low in N (the gnt-high cycle is a blackout for that requester).
REQ-006 SHALL register the winner's addr, wdata and wr_en onto memory_address, memory_data_out and wr_enables, and assert the winner's gnt, all in cycle N+1 only.
REQ-007 SHALL drive wr_enables = 0 in every cycle with no granted command; memory_address and memory_data_out hold their last values.
REQ-008 SHALL, for a granted read (wr_en = 0), capture memory_data_in at the end of N+1 into the requester's rdata and pulse its rvalid in N+2; rdata holds until the next read for that requester.
REQ-009 SHALL NOT pulse rvalid for writes.
REQ-010 SHALL issue at most one command per cycle; a lone requester is served every second cycle, and two contending requesters are interleaved at full bus rate.
REQ-011 SHALL, with POLICY 0, grant CPU on contention unless the starve counter equals STARVE_LIMIT, in which case DMA wins.
REQ-012 SHALL increment the starve counter on each cycle DMA is eligible but loses, saturating at STARVE_LIMIT, and clear it on a DMA win.
REQ-013 SHALL, with POLICY 1, give contention to the requester that did not win last; the last-winner flag updates only on a grant.
REQ-014 SHALL, on a single eligible requester, grant it regardless of POLICY, counter or last-winner.
REQ-015 SHALL ignore payload changes while req is low; a req dropped before gnt is legal and cancels with no side effects.
REQ-016 SHALL NOT decode addresses; private-register addresses (upper bits [15:27] = 0) pass through unchanged.

Reset
REQ-017 SHALL, while reset is high at a clock edge, clear all outputs to 0, clear the starve counter, set last-winner = DMA, and discard any command or read in flight (no gnt or rvalid in the cycles after reset).
REQ-018 SHALL make the first arbitration possible in the first cycle with reset low.

Structure
REQ-019 SHALL take SRC_CPU/SRC_DMA encodings and the POLICY_FIXED/POLICY_RR constants from the shared CPU package.
REQ-020 SHALL be a single module; no sub-module is natural at this size.

Verification
REQ-021 Lone CPU read at addr 0x00025, memory returns 0x22100005 -> cpu_gnt in N+1 with memory_address = 0x00025 and wr_enables = 0; cpu_rvalid in N+2 with cpu_rdata = 0x22100005.
REQ-022 Lone DMA byte write of 0x0000AB00 to 0x00100 with wr_en = 4'b0010 -> dma_gnt in N+1 with wr_enables = 4'b0010 for one cycle; no dma_rvalid.
REQ-023 POLICY 0, STARVE_LIMIT 4, both req held continuously -> grants alternate CPU/DMA; while DMA is blacked out, the CPU is granted and the counter never reaches 4.
REQ-024 POLICY 0, STARVE_LIMIT 2, CPU req toggled so DMA loses two contests in a row -> DMA wins the third contest and the counter then reads 0.
REQ-025 POLICY 1, both req rise together from reset -> CPU granted first, then DMA, then strict alternation.
REQ-026 Reset asserted in the cycle between a CPU read gnt and its rvalid -> no cpu_rvalid follows, and all outputs are 0 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and bus payload type for the two-requester memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned POLICY_FIXED = 0;
    localparam int unsigned POLICY_RR    = 1;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_DMA = 1'b1
    } src_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   wr_en;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU and DMA: one registered command per
// cycle, fixed-priority with starvation override or round-robin tie-break.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned POLICY       = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_wr_en,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [BE_W-1:0]   dma_wr_en,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    output logic [BE_W-1:0]   wr_enables,
    input  logic [DATA_W-1:0] memory_data_in
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              cpu_gnt_q, dma_gnt_q;
    logic              cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   wr_en_q;
    logic [CNT_W-1:0]  starve_q, starve_d;
    src_e              last_q;

    logic     cpu_elig_c, dma_elig_c, grant_c, rd_cycle_c;
    src_e     winner_c;
    mem_cmd_t cmd_c;

    // A requester is blacked out in the cycle its grant is showing.
    always_comb begin
        cpu_elig_c = cpu_req & ~cpu_gnt_q;
        dma_elig_c = dma_req & ~dma_gnt_q;
        grant_c    = cpu_elig_c | dma_elig_c;
        winner_c   = SRC_CPU;
        starve_d   = starve_q;

        if (cpu_elig_c && dma_elig_c) begin
            if (POLICY == POLICY_RR) begin
                winner_c = (last_q == SRC_DMA) ? SRC_CPU : SRC_DMA;
            end else begin
                winner_c = (starve_q == LIMIT) ? SRC_DMA : SRC_CPU;
            end
        end else if (dma_elig_c) begin
            winner_c = SRC_DMA;
        end

        if (POLICY == POLICY_FIXED) begin
            if (grant_c && winner_c == SRC_DMA) begin
                starve_d = '0;
            end else if (dma_elig_c && starve_q != LIMIT) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end else begin
            starve_d = '0;
        end

        if (winner_c == SRC_DMA) begin
            cmd_c = '{addr: dma_addr, wdata: dma_wdata, wr_en: dma_wr_en};
        end else begin
            cmd_c = '{addr: cpu_addr, wdata: cpu_wdata, wr_en: cpu_wr_en};
        end

        rd_cycle_c = (wr_en_q == BE_W'(0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_en_q      <= '0;
            starve_q     <= '0;
            last_q       <= SRC_DMA;
        end else begin
            cpu_gnt_q <= grant_c && (winner_c == SRC_CPU);
            dma_gnt_q <= grant_c && (winner_c == SRC_DMA);
            starve_q  <= starve_d;
            if (grant_c) begin
                mem_addr_q  <= cmd_c.addr;
                mem_wdata_q <= cmd_c.wdata;
                wr_en_q     <= cmd_c.wr_en;
                last_q      <= winner_c;
            end else begin
                wr_en_q <= '0;
            end
            // Read data is sampled at the end of the grant cycle.
            cpu_rvalid_q <= cpu_gnt_q && rd_cycle_c;
            dma_rvalid_q <= dma_gnt_q && rd_cycle_c;
            if (cpu_gnt_q && rd_cycle_c) begin
                cpu_rdata_q <= memory_data_in;
            end
            if (dma_gnt_q && rd_cycle_c) begin
                dma_rdata_q <= memory_data_in;
            end
        end
    end

    assign cpu_gnt         = cpu_gnt_q;
    assign dma_gnt         = dma_gnt_q;
    assign cpu_rvalid      = cpu_rvalid_q;
    assign dma_rvalid      = dma_rvalid_q;
    assign cpu_rdata       = cpu_rdata_q;
    assign dma_rdata       = dma_rdata_q;
    assign memory_address  = mem_addr_q;
    assign memory_data_out = mem_wdata_q;
    assign wr_enables      = wr_en_q;

endmodule
